// File: rtl/cpu_mulx_pkg.sv
// Shared encodings for the multi-cycle multiply sequencer: op select, FSM states
// and latency figures derived from the partial-product cell depth.
package cpu_mulx_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXUU = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_CORR,
        ST_DONE
    } state_e;

    // cnt value on which the final partial product lands in the accumulator
    function automatic int unsigned last_cnt_full(input int unsigned pp_lat);
        return 3 + pp_lat;
    endfunction

    function automatic int unsigned last_cnt_early(input int unsigned pp_lat);
        return 2 + pp_lat;
    endfunction

    // accept cycle to first out_valid cycle
    function automatic int unsigned done_lat_full(input int unsigned pp_lat);
        return 6 + pp_lat;
    endfunction

    function automatic int unsigned done_lat_early(input int unsigned pp_lat);
        return 4 + pp_lat;
    endfunction

endpackage

// File: rtl/cpu_mulx_pp16.sv
// 16x16 unsigned partial-product cell; product appears PP_LATENCY cycles after
// the operands are presented. No flow control: always accepts, always produces.
module cpu_mulx_pp16 #(
    parameter int PP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);

    logic [31:0] stage_q [PP_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PP_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= 32'(a_i) * 32'(b_i);
            for (int i = 1; i < PP_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign p_o = stage_q[PP_LATENCY-1];

endmodule

// File: rtl/cpu_mulx_sequencer.sv
// Multi-cycle 32x32 multiply (MUL/MULXUU/MULXSU/MULXSS) over one 16x16 cell; result 6+PP_LATENCY
// cycles after accept, held in DONE until out_ready. CPU_MULX_EARLY_OUT_EN shortens MUL to 4+PP_LATENCY.
module cpu_mulx_sequencer #(
    parameter int PP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] M_mul_src1,
    input  logic [31:0] M_mul_src2,
    input  logic [1:0]  M_mul_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] M_mul_result
);
    import cpu_mulx_pkg::*;

    localparam logic [2:0] LAST_FULL  = 3'(last_cnt_full(PP_LATENCY));
    localparam logic [2:0] LAST_EARLY = 3'(last_cnt_early(PP_LATENCY));
    localparam logic [2:0] PPL3       = 3'(PP_LATENCY);
    localparam logic [1:0] PPL2       = 2'(PP_LATENCY);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;

    logic [15:0] a_half, b_half;
    logic [31:0] pp;
    logic        pp_due;
    logic [1:0]  pp_idx;
    logic [63:0] addend;
    logic        early_mul;
    logic [2:0]  last_cnt;
    logic        a_signed;
    logic [31:0] corr_a, corr_b;

`ifdef CPU_MULX_EARLY_OUT_EN
    assign early_mul = (op_q == OP_MUL);
`else
    assign early_mul = 1'b0;
`endif

    // cnt bit 0 picks the A half, bit 1 the B half: aL*bL, aH*bL, aL*bH, aH*bH
    assign a_half = cnt_q[0] ? a_q[31:16] : a_q[15:0];
    assign b_half = cnt_q[1] ? b_q[31:16] : b_q[15:0];

    cpu_mulx_pp16 #(
        .PP_LATENCY(PP_LATENCY)
    ) u_pp16 (
        .clk   (clk),
        .reset (reset),
        .a_i   (a_half),
        .b_i   (b_half),
        .p_o   (pp)
    );

    assign pp_due   = (cnt_q >= PPL3);
    assign pp_idx   = cnt_q[1:0] - PPL2;
    assign last_cnt = early_mul ? LAST_EARLY : LAST_FULL;

    always_comb begin
        addend = '0;
        case (pp_idx)
            2'd0:    addend = {32'b0, pp};
            2'd3:    addend = {pp, 32'b0};
            default: addend = early_mul ? {32'b0, pp[15:0], 16'b0} : {16'b0, pp, 16'b0};
        endcase
    end

    // Unsigned-to-signed fix-up of the high word for negative operands
    assign a_signed = (op_q == OP_MULXSU) || (op_q == OP_MULXSS);
    assign corr_b   = (a_signed && a_q[31]) ? b_q : '0;
    assign corr_a   = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = M_mul_src1;
                    b_d     = M_mul_src2;
                    op_d    = M_mul_op;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (pp_due) begin
                    acc_d = acc_q + addend;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == last_cnt) begin
                    state_d = early_mul ? ST_DONE : ST_CORR;
                end
            end
            ST_CORR: begin
                acc_d[63:32] = acc_q[63:32] - corr_b - corr_a;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_MUL;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign M_mul_result = (state_q != ST_DONE) ? 32'h0 :
                          (op_q == OP_MUL)     ? acc_q[31:0] : acc_q[63:32];

endmodule

// File: tb/tb_cpu_mulx_sequencer.sv
// Directed vector bench for cpu_mulx_sequencer: results, accept-to-valid latency,
// backpressure hold and mid-operation reset.
module tb_cpu_mulx_sequencer;

    localparam int PPL = 1;
`ifdef CPU_MULX_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] M_mul_src1;
    logic [31:0] M_mul_src2;
    logic [1:0]  M_mul_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] M_mul_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_mulx_sequencer #(
        .PP_LATENCY(PPL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .M_mul_src1   (M_mul_src1),
        .M_mul_src2   (M_mul_src2),
        .M_mul_op     (M_mul_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .M_mul_result (M_mul_result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op);
        return (EARLY && op == 2'b00) ? 4 + PPL : 6 + PPL;
    endfunction

    // Issue one op at a negedge, accept on the next posedge, then count cycles
    // (accept cycle = T) until out_valid is seen; leaves the result un-consumed.
    task automatic issue_and_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid   = 1'b1;
        M_mul_op   = op;
        M_mul_src1 = a;
        M_mul_src2 = b;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        M_mul_src1 = 32'hDEAD_BEEF;
        M_mul_src2 = 32'hCAFE_F00D;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] held;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[4]  = '{2'b00, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000};
        vecs[5]  = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000};
        vecs[6]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[7]  = '{2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002};
        vecs[10] = '{2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001};
        vecs[11] = '{2'b11, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        M_mul_op   = 2'b00;
        M_mul_src1 = '0;
        M_mul_src2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", M_mul_result, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].op)));
            chk($sformatf("vec%0d_result", i), M_mul_result, vecs[i].exp);
            chk($sformatf("vec%0d_in_ready_done", i), 32'(in_ready), 32'd0);
            consume();
            chk($sformatf("vec%0d_out_valid_after", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: result and handshake frozen while a competing request waits
        issue_and_wait(2'b01, 32'h0001_0000, 32'h0003_0000, lat);
        chk("bp_first_result", M_mul_result, 32'h0000_0003);
        held = M_mul_result;
        in_valid   = 1'b1;
        M_mul_op   = 2'b01;
        M_mul_src1 = 32'h0002_0000;
        M_mul_src2 = 32'h0005_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_result", c), M_mul_result, held);
            chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_handoff_in_ready", 32'(in_ready), 32'd1);
        chk("bp_handoff_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_latency", 32'(lat), 32'(exp_lat(2'b01)));
        chk("bp_second_result", M_mul_result, 32'h0000_000A);
        consume();

        // Reset during MUL at T+3 discards the operation
        @(negedge clk);
        in_valid   = 1'b1;
        M_mul_op   = 2'b01;
        M_mul_src1 = 32'hFFFF_FFFF;
        M_mul_src2 = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", M_mul_result, 32'h0);
        held = 32'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            held = held | 32'(out_valid);
        end
        chk("rst_mid_no_stale_valid", held, 32'h0);
        issue_and_wait(2'b01, 32'h0000_0002, 32'h0000_0003, lat);
        chk("rst_after_latency", 32'(lat), 32'(exp_lat(2'b01)));
        chk("rst_after_result", M_mul_result, 32'h0000_0000);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_mulx_sequencer.md
# cpu_mulx_sequencer

Multi-cycle multiply sequencer for the Nios II custom datapath. It feeds operand halves to one 16x16 unsigned partial-product cell and accumulates the four partial products into a 64-bit product. It applies signed correction and returns either the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS). It sits between M-stage operand issue and W-stage writeback, with a valid/ready handshake on both sides.

## Interface
- PP_LATENCY, default 1: register stages inside the partial-product cell; legal values are 1 and 2.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset is synchronous and active-high.
- in_valid  in  1  an operation request is present.
- in_ready  out  1  the sequencer accepts a request; high only in IDLE.
- M_mul_src1  in  32  operand A.
- M_mul_src2  in  32  operand B.
- M_mul_op  in  2  operation select: 00 MUL, 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS.
- out_valid  out  1  result is available; high only in DONE.
- out_ready  in  1  the consumer takes the result.
- M_mul_result  out  32  selected product word; held stable while out_valid is high.

## Operation
- States: IDLE, MUL, CORR, DONE.
- IDLE: a transfer occurs when in_valid and in_ready are both high. Operands and op are registered, the accumulator is cleared, cnt is set to 0, and the state moves to MUL.
- MUL, partial-product issue:
  - On cnt 0..3, present to the cell: aL*bL, aH*bL, aL*bH, aH*bH, in that order.
  - A product is added to the 64-bit accumulator PP_LATENCY cycles after issue.
  - Shifts: 0 for aL*bL, 16 for the two cross products, 32 for aH*bH.
  - The last add occurs at cnt = 3+PP_LATENCY. The state then moves to CORR.
- CORR: one cycle; affects the high 32 bits only, mod 2^32.
  - Subtract B if the op treats A as signed and A[31]=1.
  - Subtract A if the op is MULXSS and B[31]=1.
  - MUL and MULXUU pass through unchanged.
- DONE:
  - M_mul_result is acc[31:0] for MUL and acc[63:32] otherwise.
  - out_valid stays high until out_ready, then the state moves to IDLE.
  - in_ready stays low in DONE, so no request is accepted in the same cycle as a result handoff.
- Inputs are ignored outside IDLE.
- Reset mid-operation: the next state is IDLE, and all accumulated data and the pending result are discarded.
- Output values during and after reset: in_ready=1, out_valid=0, M_mul_result=0, accumulator=0, cell output registers=0.

## Timing
- Accept in cycle T. MUL occupies T+1 to T+4+PP_LATENCY, CORR is T+5+PP_LATENCY, and out_valid first rises at T+6+PP_LATENCY (T+7 at the default).
- Minimum spacing between accepts is 7+PP_LATENCY cycles, with out_ready held high.
- With out_ready low, DONE holds indefinitely and the result does not change.
- The cell output is valid exactly PP_LATENCY cycles after issue. The sequencer has no other dependence on the cell.

## Configuration
- CPU_MULX_EARLY_OUT_EN, when defined:
  - For MUL, only aL*bL, aH*bL and aL*bH are issued (cnt 0..2).
  - Cross products contribute only their low halves to acc[31:16].
  - The last add is at cnt = 2+PP_LATENCY, CORR is skipped, and out_valid rises at T+4+PP_LATENCY.
  - MULX ops keep the full sequence.
- When not defined: all ops use the full sequence and the same latency.

## Structure
- Package cpu_mulx_pkg holds:
  - the op encoding constants;
  - the state enum;
  - the derived latency constants (full sequence and early-out).
- Sub-module cpu_mulx_pp16: 16x16 unsigned multiplier with a 32-bit product and PP_LATENCY output register stages, cleared synchronously by reset.

## Test plan
- MULXUU, A=0xFFFFFFFF, B=0xFFFFFFFF -> M_mul_result=0xFFFFFFFE; out_valid rises at T+7 (PP_LATENCY=1).
- MULXSS, A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000000. MULXSU with the same operands -> 0xFFFFFFFF.
- MULXSS, A=0x80000000, B=0x80000000 -> 0x40000000.
- MUL, A=0x00012345, B=0x00010000 -> 0x23450000. out_valid rises at T+7, or at T+5 with CPU_MULX_EARLY_OUT_EN.
- Backpressure: hold out_ready low for 10 cycles -> out_valid and the result stay stable and in_ready stays 0; a new in_valid is ignored until one cycle after out_ready.
- Assert reset at T+3 of an operation -> next cycle in_ready=1 and out_valid=0; a following MULXUU 2x3 -> 0x00000000 with no stale data.
